// File: rtl/pipe_reg_skid_if.sv
// Valid/ready beat carrying {pc, inst} between two pipeline stages.
// The master drives the beat; the slave answers with ready.
interface pipe_reg_skid_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [ILEN-1:0] inst;

  modport master (output valid, pc, inst, input ready);
  modport slave  (input valid, pc, inst, output ready);
endinterface

// File: rtl/pipe_reg_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// flush-to-bubble and a saturating count of consumed bubbles.
module pipe_reg_skid #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INST  = ILEN'(32'h0000_0013),
  parameter logic [XLEN-1:0] BUBBLE_PC = '0,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_reg_skid_if.slave   in_if,
  pipe_reg_skid_if.master  out_if,
  input  logic             flush_i,
  output logic             out_bubble_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } beat_t;

  localparam beat_t BUBBLE = '{pc: BUBBLE_PC, inst: NOP_INST};

  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  beat_t            m_q, m_d;
  beat_t            s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  beat_t            in_beat;
  logic             acc;
  logic             fire;

  assign in_beat = '{pc: in_if.pc, inst: in_if.inst};
  assign acc     = in_if.valid & ~s_valid_q;
  assign fire    = m_valid_q & out_if.ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    m_valid_d = m_valid_q;
    m_d       = m_q;
    s_valid_d = s_valid_q;
    s_d       = s_q;
    cnt_d     = cnt_q;

    if (flush_i) begin
      m_valid_d = 1'b0;
      m_d       = BUBBLE;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || fire) begin
      // S full implies in_ready=0, so S and the input never compete for M.
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_d       = s_q;
        s_valid_d = 1'b0;
      end else if (acc) begin
        m_valid_d = 1'b1;
        m_d       = in_beat;
      end else begin
        m_valid_d = 1'b0;
        m_d       = BUBBLE;
      end
    end else if (acc) begin
      s_valid_d = 1'b1;
      s_d       = in_beat;
    end

    if (out_if.ready && !m_valid_q && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      // NOTE: payloads are reset because the empty-stage outputs come straight from M.
      m_q       <= BUBBLE;
      s_q       <= BUBBLE;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_q       <= m_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_if.ready   = ~s_valid_q;
  assign out_if.valid  = m_valid_q;
  assign out_if.pc     = m_q.pc;
  assign out_if.inst   = m_q.inst;
  assign out_bubble_o  = ~m_valid_q;
  assign bubble_cnt_o  = cnt_q;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: directed vector table, reset and counter sequences,
// then random traffic against a queue-based model of the stage.
module tb_pipe_reg_skid;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned CNT_W   = 4;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             bubble;
  logic [CNT_W-1:0] cnt;

  pipe_reg_skid_if #(.XLEN(XLEN), .ILEN(ILEN)) up_bus ();
  pipe_reg_skid_if #(.XLEN(XLEN), .ILEN(ILEN)) dn_bus ();

  pipe_reg_skid #(
    .XLEN (XLEN),
    .ILEN (ILEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_if       (up_bus),
    .out_if      (dn_bus),
    .flush_i     (flush),
    .out_bubble_o(bubble),
    .bubble_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: the stage is a FIFO of at most two beats plus a bubble counter.
  typedef struct {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } beat_t;

  beat_t       mq[$];
  int unsigned mcnt;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  task automatic model_reset();
    mq.delete();
    mcnt = 0;
  endtask

  // Drive one cycle's inputs, advance the model, then step past the clock edge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl);
    bit acc, fire;
    up_bus.valid = v;
    up_bus.pc    = pc;
    up_bus.inst  = inst;
    dn_bus.ready = ordy;
    flush        = fl;
    acc  = v && (mq.size() < 2);
    fire = (mq.size() > 0) && ordy;
    if (ordy && mq.size() == 0 && mcnt != CNT_MAX) mcnt++;
    if (fl) mq.delete();
    else begin
      if (fire) void'(mq.pop_front());
      if (acc)  mq.push_back('{pc: pc, inst: inst});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic        ev;
    logic [31:0] epc, einst;
    ev    = mq.size() > 0;
    epc   = ev ? mq[0].pc : 32'h0;
    einst = ev ? mq[0].inst : NOP;
    check({tag, " out_valid"}, dn_bus.valid, ev);
    check({tag, " out_pc"}, dn_bus.pc, epc);
    check({tag, " out_inst"}, dn_bus.inst, einst);
    check({tag, " in_ready"}, up_bus.ready, mq.size() < 2);
    check({tag, " out_bubble"}, bubble, !ev);
    check({tag, " bubble_cnt"}, cnt, mcnt);
  endtask

  task automatic idle_inputs();
    up_bus.valid = 1'b0;
    up_bus.pc    = '0;
    up_bus.inst  = '0;
    dn_bus.ready = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        exp_v;
    logic [31:0] exp_pc;
    logic        exp_rdy;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic ordy,
                              input logic fl, input logic ev, input logic [31:0] epc,
                              input logic erdy);
    vec_t r;
    r.v = v; r.pc = pc; r.ordy = ordy; r.fl = fl;
    r.exp_v = ev; r.exp_pc = epc; r.exp_rdy = erdy;
    return r;
  endfunction

  vec_t vecs[21];

  initial begin
    // Streaming
    vecs[0]  = mk(1, 32'h00, 1, 0, 1, 32'h00, 1);
    vecs[1]  = mk(1, 32'h04, 1, 0, 1, 32'h04, 1);
    vecs[2]  = mk(1, 32'h08, 1, 0, 1, 32'h08, 1);
    vecs[3]  = mk(0, 32'h00, 1, 0, 0, 32'h00, 1);
    // Stall: 0x10 held in M, 0x14 absorbed in S, then drained in order
    vecs[4]  = mk(1, 32'h10, 0, 0, 1, 32'h10, 1);
    vecs[5]  = mk(1, 32'h14, 0, 0, 1, 32'h10, 0);
    vecs[6]  = mk(0, 32'h00, 0, 0, 1, 32'h10, 0);
    vecs[7]  = mk(0, 32'h00, 1, 0, 1, 32'h14, 1);
    vecs[8]  = mk(0, 32'h00, 1, 0, 0, 32'h00, 1);
    // Flush with M and S full and an input pending
    vecs[9]  = mk(1, 32'h20, 0, 0, 1, 32'h20, 1);
    vecs[10] = mk(1, 32'h24, 0, 0, 1, 32'h20, 0);
    vecs[11] = mk(1, 32'h28, 0, 1, 0, 32'h00, 1);
    vecs[12] = mk(0, 32'h00, 1, 0, 0, 32'h00, 1);
    // Flush discards a beat accepted in the same cycle
    vecs[13] = mk(1, 32'h2C, 1, 1, 0, 32'h00, 1);
    // S full, downstream ready, input valid: S moves up, input refused
    vecs[14] = mk(1, 32'h30, 0, 0, 1, 32'h30, 1);
    vecs[15] = mk(1, 32'h34, 0, 0, 1, 32'h30, 0);
    vecs[16] = mk(1, 32'h38, 1, 0, 1, 32'h34, 1);
    vecs[17] = mk(1, 32'h38, 1, 0, 1, 32'h38, 1);
    vecs[18] = mk(0, 32'h00, 1, 0, 0, 32'h00, 1);
    // Flush while firing and accepting
    vecs[19] = mk(1, 32'h40, 1, 0, 1, 32'h40, 1);
    vecs[20] = mk(1, 32'h44, 1, 1, 0, 32'h00, 1);

    idle_inputs();
    model_reset();
    #13;
    check("reset out_valid", dn_bus.valid, 1'b0);
    check("reset out_inst", dn_bus.inst, NOP);
    check("reset in_ready", up_bus.ready, 1'b1);
    check("reset bubble_cnt", cnt, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cycle(vecs[i].v, vecs[i].pc, inst_of(vecs[i].pc), vecs[i].ordy, vecs[i].fl);
      check({tag, " out_valid"}, dn_bus.valid, vecs[i].exp_v);
      check({tag, " out_pc"}, dn_bus.pc, vecs[i].exp_pc);
      check({tag, " out_inst"}, dn_bus.inst, vecs[i].exp_v ? inst_of(vecs[i].exp_pc) : NOP);
      check({tag, " in_ready"}, up_bus.ready, vecs[i].exp_rdy);
      check({tag, " out_bubble"}, bubble, !vecs[i].exp_v);
      check({tag, " bubble_cnt"}, cnt, mcnt);
    end

    // Asynchronous reset mid-stream with M and S both full
    cycle(1, 32'h50, inst_of(32'h50), 0, 0);
    cycle(1, 32'h54, inst_of(32'h54), 0, 0);
    check("pre-reset in_ready", up_bus.ready, 1'b0);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", dn_bus.valid, 1'b0);
    check("midreset out_inst", dn_bus.inst, NOP);
    check("midreset out_pc", dn_bus.pc, 32'h0);
    check("midreset in_ready", up_bus.ready, 1'b1);
    check("midreset bubble_cnt", cnt, 0);
    #3 rst_n = 1'b1;
    model_reset();

    // Counter: ramps on ready empty cycles, holds on stalled ones, survives flush, saturates
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 1, 0);
      check("cnt ramp", cnt, k + 1);
    end
    for (int k = 0; k < 2; k++) begin
      cycle(0, 0, 0, 0, 0);
      check("cnt stalled hold", cnt, 3);
    end
    cycle(0, 0, 0, 1, 1);
    check("cnt across flush", cnt, 4);
    for (int k = 0; k < 16; k++) begin
      cycle(0, 0, 0, 1, 0);
      check("cnt saturate", cnt, (4 + k + 1 > 15) ? 15 : 4 + k + 1);
    end
    cycle(0, 0, 0, 0, 0);
    check("cnt saturated stall", cnt, 15);

    // Random traffic against the FIFO model, with periodic resets
    for (int b = 0; b < 10; b++) begin
      do_reset();
      check_model("rand reset");
      for (int c = 0; c < 200; c++) begin
        cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
              $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        check_model("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
